multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences one shared memory port between instruction fetch and load/store, and steers the PC, IR, ALU, immediate and writeback muxes around the existing immediate generator and ALU. Every instruction executes as a series of FETCH/DECODE/EXEC/MEM/WB states, with memory wait-state handling and a retired-instruction counter.

---
 rtl/mctrl_pkg.sv | 54 +++++
 rtl/mctrl_opdec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller:
// state enum, opcode constants, mux select encodings and the opcode class vector.
package mctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_IMM   = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b01;
  localparam logic [1:0] ALU_CMP   = 2'b10;

  // One-hot instruction class; all-zero means illegal opcode.
  typedef struct packed {
    logic op_imm;
    logic op;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } op_class_t;

endpackage

// File: rtl/mctrl_opdec.sv
// Combinational RV32I opcode classifier: one-hot class vector plus illegal flag.
module mctrl_opdec
  import mctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_t        cls_o,
  output logic             illegal_o
);

  always_comb begin
    cls_o     = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP_IMM: cls_o.op_imm = 1'b1;
      OPC_OP:     cls_o.op     = 1'b1;
      OPC_LOAD:   cls_o.load   = 1'b1;
      OPC_STORE:  cls_o.store  = 1'b1;
      OPC_BRANCH: cls_o.branch = 1'b1;
      OPC_JAL:    cls_o.jal    = 1'b1;
      OPC_JALR:   cls_o.jalr   = 1'b1;
      OPC_LUI:    cls_o.lui    = 1'b1;
      OPC_AUIPC:  cls_o.auipc  = 1'b1;
      default:    illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sharing one memory port between fetch and load/store.
// Define MCTRL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        retired,
  output logic [31:0] retire_cnt,
  output logic        err,
  output logic [2:0]  state
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retire_cnt_q;
  logic               err_q;
  logic               err_set;
  logic               timeout;
  op_class_t          cls;
  logic               illegal;
  logic               unused_instr;

  assign unused_instr = ^instr[31:OPC_W];

  mctrl_opdec u_opdec (
    .opcode_i  (instr[OPC_W-1:0]),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  assign timeout    = (wait_q == WAIT_LIMIT);
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;
  assign err        = err_q;

  // Wait counter runs only while a request is outstanding; any other cycle clears it.
  assign wait_d = (mem_req && !mem_ack) ? wait_q + WAIT_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      wait_q       <= '0;
      retire_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retired) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  // Next-state and strobe decode; ack is checked before timeout so a late ack wins.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    retired   = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
`ifdef MCTRL_TRAP_EN
          err_set = 1'b1;
          state_d = ST_TRAP;
`else
          pc_we   = 1'b1;
          retired = 1'b1;
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        if (cls.op_imm || cls.op) begin
          alu_b_sel = cls.op_imm;
          alu_op    = ALU_FUNCT;
        end else if (cls.load || cls.store) begin
          alu_b_sel = 1'b1;
          state_d   = ST_MEM;
        end else if (cls.branch) begin
          alu_op  = ALU_CMP;
          pc_we   = 1'b1;
          pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
          retired = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.auipc) begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end else if (cls.jalr) begin
          alu_b_sel = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = cls.store;
        if (mem_ack) begin
          if (cls.store) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retired   = 1'b1;
        alu_b_sel = cls.jalr;
        if (cls.load)                wb_sel = WB_MEM;
        else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
        else if (cls.lui)            wb_sel = WB_IMM;
        if (cls.jal)                 pc_sel = PC_IMM;
        else if (cls.jalr)           pc_sel = PC_JALR;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; honours MCTRL_TRAP_EN like the RTL.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ack;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel, alu_b_sel;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        retired;
  logic [31:0] retire_cnt;
  logic        err;
  logic [2:0]  state;
  logic [14:0] ctl_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .br_taken   (br_taken),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_sel    (mem_sel),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .retired    (retired),
    .retire_cnt (retire_cnt),
    .err        (err),
    .state      (state)
  );

  assign ctl_obs = {mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel,
                    alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, retired};

  function automatic logic [14:0] cw(input logic req, input logic sel, input logic we,
                                     input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                     input logic as, input logic bs, input logic [1:0] aop,
                                     input logic rwe, input logic [1:0] wbs, input logic ret);
    return {req, sel, we, irwe, pcwe, pcs, as, bs, aop, rwe, wbs, ret};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs in the low phase, check, advance to next falling edge.
  task automatic cyc(input string tag, input logic ack, input logic br,
                     input logic [2:0] est, input logic [14:0] ectl);
    mem_ack  = ack;
    br_taken = br;
    #1;
    chk({tag, ".state"}, 32'(state), 32'(est));
    chk({tag, ".ctl"}, 32'(ctl_obs), 32'(ectl));
    @(negedge clk);
  endtask

  task automatic run4(input string tag, input logic [31:0] iw,
                      input logic [14:0] exec_ctl, input logic [14:0] wb_ctl);
    instr = iw;
    cyc({tag, ".fetch"}, 1'b1, 1'b0, 3'd1, cw(1,0,0,1,0,2'b00,0,0,2'b00,0,2'b00,0));
    cyc({tag, ".decode"}, 1'b0, 1'b0, 3'd2, 15'd0);
    cyc({tag, ".exec"}, 1'b0, 1'b0, 3'd3, exec_ctl);
    cyc({tag, ".wb"}, 1'b0, 1'b0, 3'd5, wb_ctl);
  endtask

  initial begin
    logic [14:0] c_fetch, c_req, c_wb_alu;
    c_fetch  = cw(1,0,0,1,0,2'b00,0,0,2'b00,0,2'b00,0);
    c_req    = cw(1,0,0,0,0,2'b00,0,0,2'b00,0,2'b00,0);
    c_wb_alu = cw(0,0,0,0,1,2'b00,0,0,2'b00,1,2'b00,1);

    rst = 1'b1; instr = 32'h0; br_taken = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.ctl", 32'(ctl_obs), 32'd0);
    chk("rst.cnt", retire_cnt, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("boot", 1'b0, 1'b0, 3'd0, 15'd0);

    // ADDI x1,x0,5 with zero-wait fetch
    run4("addi", 32'h0050_0093, cw(0,0,0,0,0,2'b00,0,1,2'b01,0,2'b00,0), c_wb_alu);
    chk("addi.cnt", retire_cnt, 32'd1);

    // LW x2,0(x0) with 3 wait cycles in MEM
    instr = 32'h0000_2103;
    cyc("lw.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("lw.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("lw.exec", 1'b0, 1'b0, 3'd3, cw(0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0));
    for (int i = 0; i < 3; i++)
      cyc("lw.memwait", 1'b0, 1'b0, 3'd4, cw(1,1,0,0,0,2'b00,0,0,2'b00,0,2'b00,0));
    cyc("lw.memack", 1'b1, 1'b0, 3'd4, cw(1,1,0,0,0,2'b00,0,0,2'b00,0,2'b00,0));
    cyc("lw.wb", 1'b0, 1'b0, 3'd5, cw(0,0,0,0,1,2'b00,0,0,2'b00,1,2'b01,1));
    chk("lw.cnt", retire_cnt, 32'd2);

    // BEQ taken then not taken
    instr = 32'h0000_0063;
    cyc("beq1.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("beq1.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("beq1.exec", 1'b0, 1'b1, 3'd3, cw(0,0,0,0,1,2'b01,0,0,2'b10,0,2'b00,1));
    cyc("beq0.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("beq0.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("beq0.exec", 1'b0, 1'b0, 3'd3, cw(0,0,0,0,1,2'b00,0,0,2'b10,0,2'b00,1));
    chk("beq.cnt", retire_cnt, 32'd4);

    // SW x2,0(x0) zero-wait
    instr = 32'h0020_2023;
    cyc("sw.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("sw.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("sw.exec", 1'b0, 1'b0, 3'd3, cw(0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0));
    cyc("sw.mem", 1'b1, 1'b0, 3'd4, cw(1,1,1,0,1,2'b00,0,0,2'b00,0,2'b00,1));
    chk("sw.cnt", retire_cnt, 32'd5);

    run4("jal", 32'h0000_006F, 15'd0, cw(0,0,0,0,1,2'b01,0,0,2'b00,1,2'b10,1));
    run4("jalr", 32'h0000_8067, cw(0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0),
         cw(0,0,0,0,1,2'b10,0,1,2'b00,1,2'b10,1));
    run4("lui", 32'h0000_10B7, 15'd0, cw(0,0,0,0,1,2'b00,0,0,2'b00,1,2'b11,1));
    run4("auipc", 32'h0000_0097, cw(0,0,0,0,0,2'b00,1,1,2'b00,0,2'b00,0), c_wb_alu);
    chk("misc.cnt", retire_cnt, 32'd9);

    // ADD with ack arriving exactly when the wait count reaches MAX_WAIT
    instr = 32'h0020_81B3;
    for (int i = 0; i < 15; i++)
      cyc("add.fwait", 1'b0, 1'b0, 3'd1, c_req);
    cyc("add.fack", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("add.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("add.exec", 1'b0, 1'b0, 3'd3, cw(0,0,0,0,0,2'b00,0,0,2'b01,0,2'b00,0));
    cyc("add.wb", 1'b0, 1'b0, 3'd5, c_wb_alu);
    chk("add.cnt", retire_cnt, 32'd10);
    chk("add.err", 32'(err), 32'd0);

    // Illegal opcode 0x7F
    instr = 32'h0000_007F;
    cyc("ill.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
`ifdef MCTRL_TRAP_EN
    cyc("ill.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("ill.trap", 1'b1, 1'b0, 3'd7, 15'd0);
    cyc("ill.trap2", 1'b0, 1'b0, 3'd7, 15'd0);
    chk("ill.err", 32'(err), 32'd1);
    chk("ill.cnt", retire_cnt, 32'd10);
`else
    cyc("ill.decode", 1'b0, 1'b0, 3'd2, cw(0,0,0,0,1,2'b00,0,0,2'b00,0,2'b00,1));
    cyc("ill.next", 1'b0, 1'b0, 3'd1, c_req);
    chk("ill.err", 32'(err), 32'd0);
    chk("ill.cnt", retire_cnt, 32'd11);
`endif

    rst = 1'b1;
    #1;
    chk("rst2.state", 32'(state), 32'd0);
    chk("rst2.err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("boot2", 1'b0, 1'b0, 3'd0, 15'd0);

    // Reset asserted in the middle of a store's MEM wait
    instr = 32'h0020_2023;
    cyc("swr.fetch", 1'b1, 1'b0, 3'd1, c_fetch);
    cyc("swr.decode", 1'b0, 1'b0, 3'd2, 15'd0);
    cyc("swr.exec", 1'b0, 1'b0, 3'd3, cw(0,0,0,0,0,2'b00,0,1,2'b00,0,2'b00,0));
    mem_ack = 1'b0;
    #1;
    chk("swr.memreq", 32'(mem_req), 32'd1);
    chk("swr.memwe", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("swr.rst.req", 32'(mem_req), 32'd0);
    chk("swr.rst.state", 32'(state), 32'd0);
    chk("swr.rst.cnt", retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("boot3", 1'b0, 1'b0, 3'd0, 15'd0);

    // Fetch never acknowledged: 16 request cycles then HALT
    for (int i = 0; i < 16; i++)
      cyc("to.fwait", 1'b0, 1'b0, 3'd1, c_req);
    cyc("to.halt", 1'b0, 1'b0, 3'd6, 15'd0);
    chk("to.err", 32'(err), 32'd1);
    cyc("to.halt.ack", 1'b1, 1'b0, 3'd6, 15'd0);
    cyc("to.halt.br", 1'b0, 1'b1, 3'd6, 15'd0);
    chk("to.cnt", retire_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
